// File: rtl/sseg_scan_decoder_pkg.sv
// Shared 7-segment code table (bit order gfedcba, active LOW) and decoder result type.
// The encoder and this decoder both draw on these constants, so the table exists only once.
package sseg_scan_decoder_pkg;

    localparam logic [6:0] SSEG_0 = 7'b1000000;
    localparam logic [6:0] SSEG_1 = 7'b1111001;
    localparam logic [6:0] SSEG_2 = 7'b0100100;
    localparam logic [6:0] SSEG_3 = 7'b0110000;
    localparam logic [6:0] SSEG_4 = 7'b0011001;
    localparam logic [6:0] SSEG_5 = 7'b0010010;
    localparam logic [6:0] SSEG_6 = 7'b0000010;
    localparam logic [6:0] SSEG_7 = 7'b1111000;
    localparam logic [6:0] SSEG_8 = 7'b0000000;
    localparam logic [6:0] SSEG_9 = 7'b0010000;
    localparam logic [6:0] SSEG_X = 7'b0110110;

    // One decoded display position: the error flag and the recovered nibble.
    typedef struct packed {
        logic       err;
        logic [3:0] bcd;
    } digit_t;

endpackage

// File: rtl/sseg_scan_decoder_sseg2bcd.sv
// Combinational segment-pattern to BCD decoder, the exact inverse of the encoder table.
module sseg2bcd
    import sseg_scan_decoder_pkg::*;
(
    input  logic [6:0] seg_i,
    output digit_t     digit_o
);

    // Map each legal pattern to its digit; every other pattern reports an error nibble.
    always_comb begin
        digit_o = '{err: 1'b1, bcd: 4'hF};
        case (seg_i)
            SSEG_0:  digit_o = '{err: 1'b0, bcd: 4'd0};
            SSEG_1:  digit_o = '{err: 1'b0, bcd: 4'd1};
            SSEG_2:  digit_o = '{err: 1'b0, bcd: 4'd2};
            SSEG_3:  digit_o = '{err: 1'b0, bcd: 4'd3};
            SSEG_4:  digit_o = '{err: 1'b0, bcd: 4'd4};
            SSEG_5:  digit_o = '{err: 1'b0, bcd: 4'd5};
            SSEG_6:  digit_o = '{err: 1'b0, bcd: 4'd6};
            SSEG_7:  digit_o = '{err: 1'b0, bcd: 4'd7};
            SSEG_8:  digit_o = '{err: 1'b0, bcd: 4'd8};
            SSEG_9:  digit_o = '{err: 1'b0, bcd: 4'd9};
            SSEG_X:  digit_o = '{err: 1'b1, bcd: 4'hF};
            default: digit_o = '{err: 1'b1, bcd: 4'hF};
        endcase
    end

endmodule

// File: rtl/sseg_scan_decoder.sv
// Multiplexed 7-segment bus receiver: registers the anode/segment bus, waits for a
// stable dwell on one position, decodes it to BCD and pulses when a full frame is seen.
module sseg_scan_decoder
    import sseg_scan_decoder_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DIGITS-1:0]   an,
    input  logic [6:0]          sseg,
    output logic [4*DIGITS-1:0] bcd,
    output logic [DIGITS-1:0]   digit_err,
    output logic                frame_valid,
    output logic                mux_err
);

    localparam int PW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int ZW = $clog2(DIGITS + 1);
    localparam logic [CNT_W-1:0] STAB_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] STAB_ACC = CNT_W'(STABLE_CYCLES - 1);

    logic [DIGITS-1:0]   an_q;
    logic [6:0]          sseg_q;
    logic [CNT_W-1:0]    stab_cnt_q, stab_cnt_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [DIGITS-1:0]   digit_err_q, digit_err_d;
    logic [DIGITS-1:0]   seen_q, seen_d;
    logic                frame_valid_q, frame_valid_d;
    logic                mux_err_q, mux_err_d;

    logic [ZW-1:0]       in_lows, q_lows;
    logic [PW-1:0]       q_pos;
    logic                in_legal, in_same, accept;
    logic [DIGITS-1:0]   seen_set;
    digit_t              dec;

    sseg2bcd u_dec (
        .seg_i   (sseg_q),
        .digit_o (dec)
    );

    // Count active-LOW anodes on the incoming and registered buses; locate the registered position.
    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        in_lows = '0;
        q_lows  = '0;
        q_pos   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!an[i]) begin
                in_lows = in_lows + ZW'(1);
            end
            if (!an_q[i]) begin
                q_lows = q_lows + ZW'(1);
                q_pos  = PW'(i);
            end
        end
    end

    // Stability counter: counts identical legal samples, saturates, and strobes acceptance once per dwell.
    always_comb begin
        in_legal   = (in_lows == ZW'(1));
        in_same    = (an == an_q) && (sseg == sseg_q);
        accept     = 1'b0;
        stab_cnt_d = '0;
        if (in_legal && !in_same) begin
            stab_cnt_d = CNT_W'(1);
        end else if (in_legal && (stab_cnt_q == STAB_MAX)) begin
            stab_cnt_d = STAB_MAX;
        end else if (in_legal) begin
            stab_cnt_d = stab_cnt_q + CNT_W'(1);
            accept     = (stab_cnt_q == STAB_ACC);
        end
    end

    // Digit capture, seen-mask bookkeeping, frame pulse and mux-fault pulse.
    always_comb begin
        bcd_d         = bcd_q;
        digit_err_d   = digit_err_q;
        seen_d        = seen_q;
        seen_set      = seen_q;
        frame_valid_d = 1'b0;
        mux_err_d     = (q_lows > ZW'(1));
        if (accept) begin
            bcd_d[4*q_pos +: 4] = dec.bcd;
            digit_err_d[q_pos]  = dec.err;
            seen_set[q_pos]     = 1'b1;
            if (&seen_set) begin
                frame_valid_d = 1'b1;
                seen_d        = '0;
            end else begin
                seen_d = seen_set;
            end
        end
    end

    // Input stage and all architectural state, synchronously reset.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            an_q          <= '1;
            sseg_q        <= '1;
            stab_cnt_q    <= '0;
            bcd_q         <= '0;
            digit_err_q   <= '0;
            seen_q        <= '0;
            frame_valid_q <= 1'b0;
            mux_err_q     <= 1'b0;
        end else begin
            an_q          <= an;
            sseg_q        <= sseg;
            stab_cnt_q    <= stab_cnt_d;
            bcd_q         <= bcd_d;
            digit_err_q   <= digit_err_d;
            seen_q        <= seen_d;
            frame_valid_q <= frame_valid_d;
            mux_err_q     <= mux_err_d;
        end
    end

    assign bcd         = bcd_q;
    assign digit_err   = digit_err_q;
    assign frame_valid = frame_valid_q;
    assign mux_err     = mux_err_q;

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Directed bench for sseg_scan_decoder: expected captures are queued when a dwell is
// driven and popped on the cycle the decoder should publish them; all outputs are
// compared every cycle on the falling edge.
module tb_sseg_scan_decoder;

    localparam int SC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  an = 4'b1111;
    logic [6:0]  sseg = 7'b1111111;
    logic [15:0] bcd;
    logic [3:0]  digit_err;
    logic        frame_valid;
    logic        mux_err;

    sseg_scan_decoder #(
        .DIGITS        (4),
        .STABLE_CYCLES (SC),
        .CNT_W         (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .an          (an),
        .sseg        (sseg),
        .bcd         (bcd),
        .digit_err   (digit_err),
        .frame_valid (frame_valid),
        .mux_err     (mux_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        logic [15:0] bcd;
        logic [3:0]  err;
        logic        fv;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [15:0] cur_bcd = '0;
    logic [3:0]  cur_err = '0;
    logic [15:0] pl_bcd = '0;
    logic [3:0]  pl_err = '0;
    logic [3:0]  pl_seen = '0;
    logic        last_bad = 1'b0;
    logic        exp_mux = 1'b0;
    logic [6:0]  seg_tab [12];

    function automatic int lows(input logic [3:0] a);
        int n = 0;
        for (int i = 0; i < 4; i++) if (!a[i]) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: drive at the falling edge, advance, then compare everything.
    task automatic step(input logic [3:0] a, input logic [6:0] s);
        exp_t e;
        logic fv;
        an   = a;
        sseg = s;
        @(posedge clk);
        cyc++;
        exp_mux  = rst ? 1'b0 : last_bad;
        last_bad = rst ? 1'b0 : (lows(a) > 1);
        @(negedge clk);
        fv = 1'b0;
        if (rst) begin
            cur_bcd = '0;
            cur_err = '0;
        end else if (sb.size() > 0 && sb[0].due == cyc) begin
            e       = sb.pop_front();
            cur_bcd = e.bcd;
            cur_err = e.err;
            fv      = e.fv;
        end
        chk("bcd", 32'(bcd), 32'(cur_bcd));
        chk("digit_err", 32'(digit_err), 32'(cur_err));
        chk("frame_valid", 32'(frame_valid), 32'(fv));
        chk("mux_err", 32'(mux_err), 32'(exp_mux));
    endtask

    // Hold a position/code for n cycles; a legal dwell of at least SC cycles queues a capture.
    task automatic hold(input logic [3:0] a, input int d, input int n);
        exp_t e;
        int   p = 0;
        if (lows(a) == 1 && n >= SC) begin
            for (int i = 0; i < 4; i++) if (!a[i]) p = i;
            pl_bcd[4*p +: 4] = (d < 10) ? 4'(d) : 4'hF;
            pl_err[p]        = (d >= 10);
            pl_seen[p]       = 1'b1;
            e.fv  = &pl_seen;
            if (e.fv) pl_seen = '0;
            e.due = cyc + SC;
            e.bcd = pl_bcd;
            e.err = pl_err;
            sb.push_back(e);
        end
        repeat (n) step(a, seg_tab[d]);
    endtask

    task automatic reset_dut(input int n);
        rst = 1'b1;
        sb.delete();
        pl_bcd  = '0;
        pl_err  = '0;
        pl_seen = '0;
        repeat (n) step(4'($urandom), 7'($urandom));
        rst = 1'b0;
    endtask

    initial begin
        seg_tab[0]  = 7'b1000000;
        seg_tab[1]  = 7'b1111001;
        seg_tab[2]  = 7'b0100100;
        seg_tab[3]  = 7'b0110000;
        seg_tab[4]  = 7'b0011001;
        seg_tab[5]  = 7'b0010010;
        seg_tab[6]  = 7'b0000010;
        seg_tab[7]  = 7'b1111000;
        seg_tab[8]  = 7'b0000000;
        seg_tab[9]  = 7'b0010000;
        seg_tab[10] = 7'b0110110;
        seg_tab[11] = 7'b1111111;
        @(negedge clk);

        // Reset with random bus activity.
        reset_dut(2);

        // Full frame 0513.
        hold(4'b1110, 3, 8);
        hold(4'b1101, 1, 8);
        hold(4'b1011, 5, 8);
        hold(4'b0111, 0, 8);
        chk("frame_bcd", 32'(bcd), 32'h0513);
        chk("frame_err", 32'(digit_err), 32'h0);

        // Glitch rejection: a short 3 never lands, the held 8 lands 4 edges after the change.
        hold(4'b1110, 0, 6);
        step(4'b1111, seg_tab[11]);
        hold(4'b1110, 3, 3);
        hold(4'b1110, 8, 6);

        // Illegal patterns, then a legal one clearing the error.
        hold(4'b1011, 10, 4);
        hold(4'b1011, 7, 4);
        hold(4'b1101, 11, 5);
        hold(4'b1101, 9, 5);

        // Mux fault, then alternating dwell/blank that never stabilises.
        repeat (5) step(4'b1100, seg_tab[8]);
        for (int i = 0; i < 3; i++) begin
            step(4'b1110, seg_tab[5]);
            step(4'b1110, seg_tab[5]);
            step(4'b1111, seg_tab[5]);
            step(4'b1111, seg_tab[5]);
        end

        // Reset mid-frame discards progress; a later full scan pulses exactly once.
        hold(4'b1110, 0, 5);
        step(4'b1111, seg_tab[11]);
        hold(4'b1101, 1, 5);
        reset_dut(1);
        hold(4'b1011, 2, 5);
        hold(4'b0111, 3, 5);
        step(4'b1111, seg_tab[11]);
        hold(4'b1110, 4, 6);
        step(4'b1111, seg_tab[11]);
        hold(4'b1101, 5, 6);
        step(4'b1111, seg_tab[11]);
        hold(4'b1011, 6, 6);
        step(4'b1111, seg_tab[11]);
        hold(4'b0111, 7, 6);
        repeat (3) step(4'b1111, seg_tab[11]);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sseg_scan_decoder.md
Name: sseg_scan_decoder

Overview:
Receive-side counterpart of the BCD-to-7-segment encoder path. It samples a multiplexed, active-LOW 7-segment display bus (anodes plus gfedcba segments) and recovers one BCD digit per display position. Each digit is accepted only after a stability window. The block flags illegal segment patterns and illegal anode states, and pulses when a complete display frame has been captured. It is used for display loopback checking and for self-test of the stopwatch display driver.

Parameters:
DIGITS, 4, number of multiplexed display positions (1..8)
STABLE_CYCLES, 4, consecutive identical samples required to accept a digit (>=2)
CNT_W, 4, width of the stability counter; must satisfy 2**CNT_W > STABLE_CYCLES

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
an  in  DIGITS  anode enables, active LOW; bit i selects position i
sseg  in  7  segment lines, active LOW, bit order gfedcba
bcd  out  4*DIGITS  recovered digits; position i occupies bits [4i+3:4i]
digit_err  out  DIGITS  bit i set when the last accepted pattern on position i was not a legal 0-9 code
frame_valid  out  1  one-cycle pulse when every position has been accepted since the previous pulse or reset
mux_err  out  1  one-cycle pulse for each sample with more than one anode LOW

Behaviour:
- Reset (rst=1 at an edge):
  - bcd=0, digit_err=0, frame_valid=0, mux_err=0.
  - Internal state: seen mask=0, stab_cnt=0, an_q=all 1, sseg_q=all 1.
- Input stage: an and sseg are registered into an_q/sseg_q every cycle.
- Sample classification, per registered sample:
  - Exactly one an_q bit LOW: legal, and that bit's index is the position.
  - All an_q bits HIGH: blank.
  - More than one an_q bit LOW: mux fault. mux_err=1 on the next cycle.
- Stability counter, updated at each edge:
  - Incoming sample legal and equal to {an_q,sseg_q}: stab_cnt increments, saturating at STABLE_CYCLES.
  - Incoming sample legal but different: stab_cnt=1.
  - Blank or mux fault: stab_cnt=0.
- Acceptance:
  - Occurs at the edge where stab_cnt goes from STABLE_CYCLES-1 to STABLE_CYCLES. This happens at most once per anode dwell.
  - Input held from before edge k is accepted at edge k+STABLE_CYCLES-1, and the outputs are visible after that edge.
  - On acceptance, position p updates bcd[4p+3:4p] and digit_err[p], and sets seen[p].
- Decode: exact inverse of the encoder table.
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9.
  - Any other pattern, including the encoder's "X" code 0110110: bcd nibble=4'hF and digit_err bit=1.
  - A legal pattern clears the digit_err bit.
- Re-acceptance of the same position within a frame overwrites its nibble; the seen mask is unchanged.
- Frame completion:
  - When acceptance makes seen all-ones, frame_valid=1 for exactly the cycle after that edge, and seen clears at the same edge.
  - bcd already holds the final nibble when frame_valid is high.
- Blank gaps between positions are tolerated. Gaps and mux faults never update bcd.
- Reset mid-frame discards partial frame progress. Completing only the remaining positions produces no frame_valid.

Decomposition:
- Shared package / include: the SSEG_0..SSEG_9 and SSEG_X constants (bit order gfedcba, active LOW). They are shared with the encoder so both directions use one table.
- Sub-module: sseg2bcd, a combinational pattern → {err, bcd[3:0]} decoder, instantiated once on sseg_q.
- Top level contains the input register, anode classification, stability counter, digit registers, seen mask and pulse logic.

Test Plan:
1. Reset: rst=1 for 2 cycles with random an/sseg → bcd=16'h0000, digit_err=4'b0000, frame_valid=0, mux_err=0 throughout.
2. Full frame (DIGITS=4, STABLE_CYCLES=4): 8 cycles per position on the following inputs → single frame_valid pulse the cycle after the last acceptance, bcd=16'h0513, digit_err=0.
   - an=1110, sseg=0110000
   - an=1101, sseg=1111001
   - an=1011, sseg=0010010
   - an=0111, sseg=1000000
3. Glitch rejection: an=1110, sseg=0110000 for 3 cycles, then sseg=0000000 held → nibble 0 never becomes 3; it becomes 8 exactly 4 edges after the change.
4. Illegal pattern: an=1011, sseg=0110110 held 4 cycles → bcd[11:8]=4'hF, digit_err[2]=1. Then sseg=1111000 held 4 cycles → bcd[11:8]=7, digit_err[2]=0.
5. Mux fault and blanking: an=1100 for 5 cycles → mux_err high 5 cycles, no bcd change. Alternate an=1110 and an=1111 every 2 cycles → never accepted.
6. Reset mid-frame: accept positions 0 and 1, pulse rst, then accept positions 2 and 3 → no frame_valid. A further full scan of all 4 positions → exactly one pulse.
